// File: rtl/ad_wave_capture.sv
// AD9280-class ADC front end: divided ad_clk, one registered sample per ad_clk rise,
// level/slope triggered capture of 2**ADDR_W samples into a read-first buffer.
module ad_wave_capture #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div_half,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_otr,
  output logic              ad_clk,
  input  logic              start,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  output logic              busy,
  output logic              done,
  output logic              otr_flag,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt, half_lim;
  logic                div_tc, ad_rise;
  logic                otr_p0;
  logic                prev_vld;
  logic [DATA_W-1:0]   prev_smp;
  logic                trig_hit;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr, wr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Terminal count index for a half-period setting; 0 behaves like 1.
  function automatic logic [DIV_W-1:0] half_to_lim(input logic [DIV_W-1:0] h);
    return (h == '0) ? '0 : h - DIV_W'(1);
  endfunction

  assign div_tc  = (div_cnt == half_lim);
  assign ad_rise = div_tc && !ad_clk;

  // ---- divider: half_lim is resampled only at terminal count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ad_clk   <= 1'b0;
      div_cnt  <= '0;
      half_lim <= '0;
    end else if (div_tc) begin
      ad_clk   <= ~ad_clk;
      div_cnt  <= '0;
      half_lim <= half_to_lim(div_half);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // ---- stage p0: sample register, valid the cycle after the ad_clk rise ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_data  <= '0;
      otr_p0    <= 1'b0;
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= ad_rise;
      if (ad_rise) begin
        smp_data <= ad_data;
        otr_p0   <= ad_otr;
      end
    end
  end

  always_comb begin
    trig_hit = 1'b1;
    case (trig_mode)
      2'b01:   trig_hit = prev_vld && (prev_smp < trig_level) && (smp_data >= trig_level);
      2'b10:   trig_hit = prev_vld && (prev_smp > trig_level) && (smp_data <= trig_level);
      default: trig_hit = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_ptr    = wr_addr;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!start && smp_valid && trig_hit) begin
          state_nxt = S_CAPTURE;
          wr_en     = 1'b1;
          wr_ptr    = '0;
        end
      end
      S_CAPTURE: begin
        if (smp_valid) begin
          wr_en = 1'b1;
          if (wr_addr == '1) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p1: control state, flags registered alongside the state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wr_addr  <= '0;
      prev_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      otr_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
      done  <= (state_nxt == S_DONE);
      if (wr_en) wr_addr <= wr_ptr + ADDR_W'(1);
      if (start && state != S_CAPTURE) begin
        prev_vld <= 1'b0;
        otr_flag <= 1'b0;
      end else begin
        if (state == S_ARMED && smp_valid) prev_vld <= 1'b1;
        if (wr_en && otr_p0) otr_flag <= 1'b1;
      end
    end
  end

  // Previous-sample history only matters once prev_vld is set.
  always_ff @(posedge clk) begin
    if (state == S_ARMED && smp_valid) prev_smp <= smp_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= smp_data;
  end

  // Non-blocking read alongside the write gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_ad_wave_capture.sv
// Directed bench for ad_wave_capture: divider table, trigger table, and hand-written
// sequences for full capture, OTR stickiness, start during capture and async reset.
module tb_ad_wave_capture;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  div_half = 8'd1;
  logic [DATA_W-1:0] ad_data = '0;
  logic              ad_otr = 1'b0;
  logic              ad_clk;
  logic              start = 1'b0;
  logic [1:0]        trig_mode = 2'b00;
  logic [DATA_W-1:0] trig_level = '0;
  logic [DATA_W-1:0] smp_data;
  logic              smp_valid;
  logic              busy;
  logic              done;
  logic              otr_flag;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  ad_wave_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .div_half(div_half), .ad_data(ad_data), .ad_otr(ad_otr),
    .ad_clk(ad_clk), .start(start), .trig_mode(trig_mode), .trig_level(trig_level),
    .smp_data(smp_data), .smp_valid(smp_valid), .busy(busy), .done(done),
    .otr_flag(otr_flag), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] div;
    logic [7:0] period;
  } div_vec_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      level;
    logic [2:0]      n;
    logic [5:0][7:0] smp;
    logic            tail;
    logic [7:0]      tail_v;
    logic [7:0]      m0;
    logic            chk_m1;
    logic [7:0]      m1;
  } trig_vec_t;

  div_vec_t  dv [4];
  trig_vec_t tv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("rst_ad_clk", 32'(ad_clk), 32'd0);
    check("rst_smp_data", 32'(smp_data), 32'd0);
    check("rst_smp_valid", 32'(smp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_otr_flag", 32'(otr_flag), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = smp_valid;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic feed(input logic [7:0] v, input logic o);
    ad_data = v;
    ad_otr  = o;
    wait_valid("feed_valid");
  endtask

  task automatic arm();
    wait_valid("arm_align");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic measure(output int per, output int nv);
    bit prev_c, seen;
    per = 0;
    nv = 0;
    prev_c = ad_clk;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = ad_clk && !prev_c;
      prev_c = ad_clk;
    end
    if (!seen) begin
      per = -1;
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      per++;
      if (smp_valid) nv++;
      seen = ad_clk && !prev_c;
      prev_c = ad_clk;
    end
  endtask

  task automatic set_tv(input int idx, input logic [1:0] mode, input logic [7:0] level,
                        input logic [2:0] n, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] s4,
                        input logic [7:0] s5, input logic tail, input logic [7:0] tail_v,
                        input logic [7:0] m0, input logic chk_m1, input logic [7:0] m1);
    tv[idx].mode   = mode;
    tv[idx].level  = level;
    tv[idx].n      = n;
    tv[idx].smp[0] = s0;
    tv[idx].smp[1] = s1;
    tv[idx].smp[2] = s2;
    tv[idx].smp[3] = s3;
    tv[idx].smp[4] = s4;
    tv[idx].smp[5] = s5;
    tv[idx].tail   = tail;
    tv[idx].tail_v = tail_v;
    tv[idx].m0     = m0;
    tv[idx].chk_m1 = chk_m1;
    tv[idx].m1     = m1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, nv;

    dv[0] = '{div: 8'd1, period: 8'd2};
    dv[1] = '{div: 8'd3, period: 8'd6};
    dv[2] = '{div: 8'd0, period: 8'd2};
    dv[3] = '{div: 8'd2, period: 8'd4};

    // mode, level, n, samples, tail?, tail value, mem[0], check mem[1]?, mem[1]
    set_tv(0, 2'b01, 8'h80, 3'd5, 8'h90, 8'h70, 8'h7F, 8'h80, 8'h81, 8'h00, 1'b0, 8'h00, 8'h80, 1'b1, 8'h81);
    set_tv(1, 2'b10, 8'h40, 3'd3, 8'h50, 8'h41, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h40, 1'b0, 8'h00);
    set_tv(2, 2'b10, 8'h40, 3'd6, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 8'h5A, 8'h5A, 1'b0, 8'h00);
    set_tv(3, 2'b11, 8'h00, 3'd2, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h33, 1'b1, 8'h34);
    set_tv(4, 2'b10, 8'h40, 3'd2, 8'h40, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0, 8'h00);
    set_tv(5, 2'b01, 8'h80, 3'd2, 8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'hC3, 8'hC3, 1'b0, 8'h00);
    set_tv(6, 2'b01, 8'h80, 3'd2, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00);
    set_tv(7, 2'b00, 8'hFF, 3'd2, 8'h44, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h44, 1'b1, 8'h45);

    do_reset();

    // Divider: discard one period after each change, then measure.
    for (int i = 0; i < 4; i++) begin
      div_half = dv[i].div;
      measure(per, nv);
      measure(per, nv);
      check($sformatf("div%0d_period", dv[i].div), per, 32'(dv[i].period));
      check($sformatf("div%0d_valids", dv[i].div), nv, 32'd1);
    end

    // Trigger table
    for (int i = 0; i < 8; i++) begin
      div_half = 8'd1;
      do_reset();
      trig_mode  = tv[i].mode;
      trig_level = tv[i].level;
      arm();
      check($sformatf("vec%0d_armed_busy", i), 32'(busy), 32'd1);
      for (int j = 0; j < int'(tv[i].n); j++) feed(tv[i].smp[j], 1'b0);
      @(negedge clk);
      if (tv[i].tail) begin
        trig_mode = 2'b00;
        feed(tv[i].tail_v, 1'b0);
        @(negedge clk);
      end
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      rd_check($sformatf("vec%0d_mem0", i), '0, tv[i].m0);
      if (tv[i].chk_m1) rd_check($sformatf("vec%0d_mem1", i), ADDR_W'(1), tv[i].m1);
    end

    // Full free-run capture of a ramp with one out-of-range sample
    div_half = 8'd1;
    do_reset();
    trig_mode = 2'b00;
    arm();
    check("ramp_otr_start", 32'(otr_flag), 32'd0);
    for (int i = 0; i < 16; i++) begin
      feed(8'(8'h10 + i), (i == 5));
      if (i == 14) begin
        check("ramp_busy_15", 32'(busy), 32'd1);
        check("ramp_done_15", 32'(done), 32'd0);
      end
    end
    @(negedge clk);
    check("ramp_done", 32'(done), 32'd1);
    check("ramp_busy_end", 32'(busy), 32'd0);
    check("ramp_otr_flag", 32'(otr_flag), 32'd1);
    feed(8'hEE, 1'b0);
    @(negedge clk);
    check("ramp_done_hold", 32'(done), 32'd1);
    for (int i = 0; i < 16; i++)
      rd_check($sformatf("ramp_mem%0d", i), ADDR_W'(i), 8'(8'h10 + i));

    // Re-arm clears flags; OTR while ARMED is ignored; start in CAPTURE is ignored
    trig_mode  = 2'b01;
    trig_level = 8'h80;
    arm();
    check("rearm_otr_clr", 32'(otr_flag), 32'd0);
    check("rearm_done_clr", 32'(done), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    feed(8'h10, 1'b1);
    feed(8'h90, 1'b0);
    feed(8'h91, 1'b0);
    pulse_start();
    feed(8'h92, 1'b0);
    @(negedge clk);
    check("armed_otr_ignored", 32'(otr_flag), 32'd0);
    check("cap_start_busy", 32'(busy), 32'd1);
    rd_check("cap_mem0", '0, 8'h90);
    rd_check("cap_mem1", ADDR_W'(1), 8'h91);
    rd_check("cap_mem2", ADDR_W'(2), 8'h92);

    // Asynchronous reset mid-capture, taken while ad_clk is high
    for (int i = 0; i < 8 && !ad_clk; i++) @(negedge clk);
    check("pre_rst_ad_clk_high", 32'(ad_clk), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ad_clk", 32'(ad_clk), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("partial_mem0", '0, 8'h90);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
